// File: rtl/snitch_shared_acc_arbiter.sv
// Shared accelerator arbiter: round-robin issue of per-core offload requests
// to one downstream unit, with an in-order routing FIFO that steers each
// response back to the core that issued it.
module snitch_shared_acc_arbiter #(
   parameter int unsigned NrCores        = 4,
   parameter int unsigned ReqWidth       = 96,
   parameter int unsigned RspWidth       = 37,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NrCores-1:0]                 req_valid_i,
   output logic [NrCores-1:0]                 req_ready_o,
   input  logic [NrCores-1:0][ReqWidth-1:0]   req_data_i,
   output logic                               acc_q_valid_o,
   input  logic                               acc_q_ready_i,
   output logic [ReqWidth-1:0]                acc_q_data_o,
   input  logic                               acc_p_valid_i,
   output logic                               acc_p_ready_o,
   input  logic [RspWidth-1:0]                acc_p_data_i,
   output logic [NrCores-1:0]                 rsp_valid_o,
   input  logic [NrCores-1:0]                 rsp_ready_i,
   output logic [RspWidth-1:0]                rsp_data_o,
   output logic                               busy_o
);

   localparam int unsigned IdxW = (NrCores > 1) ? $clog2(NrCores) : 1;
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [PtrW-1:0] ptr_t;

   idx_t            rr_ptr_q, lock_idx_q, winner, dst;
   logic            lock_q, any_valid, issue_ok, q_hs, p_hs, fifo_empty;
   idx_t            fifo_q [MaxOutstanding];
   ptr_t            rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] outstanding_q;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Pick the winner: a held grant wins outright, otherwise the first valid
   // core at or after rr_ptr. Scanning downwards lets the nearest one win.
   always_comb begin
      int unsigned c;
      c         = 0;
      winner    = lock_idx_q;
      any_valid = 1'b0;
      if (lock_q) begin
         any_valid = req_valid_i[lock_idx_q];
      end else begin
         for (int k = NrCores - 1; k >= 0; k--) begin
            c = (int'(rr_ptr_q) + k) % NrCores;
            if (req_valid_i[c]) begin
               winner    = idx_t'(c);
               any_valid = 1'b1;
            end
         end
      end
   end

   assign issue_ok      = outstanding_q < CntW'(MaxOutstanding);
   assign acc_q_valid_o = any_valid && issue_ok;
   assign acc_q_data_o  = req_data_i[winner];
   assign q_hs          = acc_q_valid_o && acc_q_ready_i;

   assign fifo_empty    = (outstanding_q == '0);
   assign dst           = fifo_q[rd_ptr_q];
   assign acc_p_ready_o = !fifo_empty && rsp_ready_i[dst];
   assign p_hs          = acc_p_valid_i && acc_p_ready_o;
   assign rsp_data_o    = acc_p_data_i;
   assign busy_o        = !fifo_empty;

   // Only the winner sees ready; responses are steered to the FIFO head.
   always_comb begin
      req_ready_o         = '0;
      req_ready_o[winner] = acc_q_ready_i && acc_q_valid_o;
      rsp_valid_o         = '0;
      if (!fifo_empty) rsp_valid_o[dst] = acc_p_valid_i;
   end

   // Round-robin pointer and grant lock: a stalled offer keeps its winner.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (q_hs) begin
         rr_ptr_q   <= idx_t'((int'(winner) + 1) % NrCores);
         lock_q     <= 1'b0;
      end else if (acc_q_valid_o) begin
         lock_q     <= 1'b1;
         lock_idx_q <= winner;
      end
   end

   // Routing FIFO of issuing core ids; its occupancy is the outstanding count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         outstanding_q <= '0;
         for (int i = 0; i < int'(MaxOutstanding); i++) fifo_q[i] <= '0;
      end else begin
         if (q_hs) begin
            fifo_q[wr_ptr_q] <= winner;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (p_hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({q_hs, p_hs})
            2'b10:   outstanding_q <= outstanding_q + CntW'(1);
            2'b01:   outstanding_q <= outstanding_q - CntW'(1);
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   // A response with nothing in flight means the downstream unit misbehaved.
   a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(acc_p_valid_i && fifo_empty));

endmodule

// File: tb/tb_snitch_shared_acc_arbiter.sv
// Randomized bench for snitch_shared_acc_arbiter against a queue-based model.
module tb_snitch_shared_acc_arbiter;

   localparam int N = 4;
   localparam int MAXO = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0][95:0] req_data;
   logic              acc_q_valid, acc_q_ready;
   logic [95:0]       acc_q_data;
   logic              acc_p_valid, acc_p_ready;
   logic [36:0]       acc_p_data;
   logic [N-1:0]      rsp_valid, rsp_ready;
   logic [36:0]       rsp_data;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // model state
   int m_rr = 0;
   bit m_lock = 0;
   int m_lock_idx = 0;
   int m_q[$];

   always #5 clk = ~clk;

   snitch_shared_acc_arbiter #(.NrCores(N), .ReqWidth(96), .RspWidth(37), .MaxOutstanding(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
      .acc_q_valid_o(acc_q_valid), .acc_q_ready_i(acc_q_ready), .acc_q_data_o(acc_q_data),
      .acc_p_valid_i(acc_p_valid), .acc_p_ready_o(acc_p_ready), .acc_p_data_i(acc_p_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .busy_o(busy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rr = 0;
      m_lock = 0;
      m_lock_idx = 0;
      m_q.delete();
   endtask

   // Called just after a negedge with inputs set: compare outputs, advance
   // the model across the posedge, and retire handshaked requests.
   task automatic tick();
      int w;
      bit any, qv, qhs, phs, nonempty;
      int head;
      logic [N-1:0] exp_rdy, exp_rv;
      #1;
      any = 0;
      w = 0;
      if (m_lock) begin
         w = m_lock_idx;
         any = req_valid[w];
      end else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (!any && req_valid[c]) begin
               w = c;
               any = 1;
            end
         end
      end
      qv = any && (m_q.size() < MAXO);
      nonempty = (m_q.size() != 0);
      head = nonempty ? m_q[0] : 0;
      exp_rdy = (qv && acc_q_ready) ? (N'(1) << w) : '0;
      exp_rv = (nonempty && acc_p_valid) ? (N'(1) << head) : '0;
      check("q_valid", acc_q_valid, qv);
      if (qv) check("q_data", acc_q_data, req_data[w]);
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, exp_rv);
      check("p_ready", acc_p_ready, nonempty && rsp_ready[head]);
      check("rsp_data", rsp_data, acc_p_data);
      check("busy", busy, nonempty);
      qhs = qv && acc_q_ready;
      phs = acc_p_valid && nonempty && rsp_ready[head];
      @(posedge clk);
      if (phs) void'(m_q.pop_front());
      if (qhs) begin
         m_q.push_back(w);
         m_rr = (w + 1) % N;
         m_lock = 0;
      end else if (qv) begin
         m_lock = 1;
         m_lock_idx = w;
      end
      @(negedge clk);
      if (qhs) req_valid[w] = 1'b0;
   endtask

   // Random inputs; a requesting core holds valid and data until accepted.
   task automatic drive(input int pnew, input int pqr, input int ppv, input int prr);
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i] && ($urandom % 100) < pnew) begin
            req_valid[i] = 1'b1;
            req_data[i] = {$urandom, $urandom, $urandom};
         end
         rsp_ready[i] = ($urandom % 100) < prr;
      end
      acc_q_ready = ($urandom % 100) < pqr;
      acc_p_valid = (m_q.size() != 0) && (($urandom % 100) < ppv);
      acc_p_data = 37'({$urandom, $urandom});
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_data = '0;
      acc_q_ready = 0;
      acc_p_valid = 0;
      acc_p_data = '0;
      rsp_ready = '0;
   endtask

   initial begin
      int guard;
      idle_inputs();
      rst_n = 0;
      #3;
      check("rst_busy", busy, 0);
      check("rst_q_valid", acc_q_valid, 0);
      check("rst_p_ready", acc_p_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      model_reset();

      // single request from core 0, then its response
      req_valid[0] = 1;
      req_data[0] = 96'h1234_5678_9abc_def0_1111_2222;
      acc_q_ready = 1;
      tick();
      acc_q_ready = 0;
      acc_p_valid = 1;
      acc_p_data = 37'h15_5555_5555;
      rsp_ready = '1;
      tick();
      idle_inputs();
      tick();

      // all cores busy, no responses: round-robin order, then gating at full
      for (int i = 0; i < 6; i++) drive(100, 100, 0, 100);
      for (int i = 0; i < 6; i++) begin
         drive(100, 100, 0, 100);
         tick();
      end
      // drain with and without concurrent issue
      for (int i = 0; i < 12; i++) begin
         drive(100, 60, 100, 100);
         tick();
      end

      // random mixes: stalls exercise the grant lock and response backpressure
      for (int i = 0; i < 1500; i++) begin
         case ((i / 250) % 3)
            0: drive(40, 30, 50, 50);
            1: drive(70, 80, 30, 80);
            default: drive(20, 50, 80, 20);
         endcase
         tick();
      end

      // build up in-flight work then reset asynchronously
      guard = 0;
      while (m_q.size() < 3 && guard < 40) begin
         drive(100, 100, 0, 0);
         tick();
         guard++;
      end
      check("inflight_reached", m_q.size() >= 3, 1);
      idle_inputs();
      #2 rst_n = 0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_p_ready", acc_p_ready, 0);
      check("arst_q_valid", acc_q_valid, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      req_valid[3] = 1;
      req_data[3] = 96'hdead_beef_cafe_f00d_0123_4567;
      acc_q_ready = 1;
      tick();
      idle_inputs();
      acc_p_valid = 1;
      acc_p_data = 37'h0a_bcde_f012;
      rsp_ready = 4'b1000;
      tick();
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout: got no finish expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
